// File: rtl/mandel_pkg.sv
// Shared constants and record types for the Mandelbrot coordinate dispatcher.
// Coordinates are signed fixed point: COORD_W bits total, FRAC_W of them fractional.
package mandel_pkg;

    localparam int COORD_W = 64;
    localparam int FRAC_W  = 56;

    // 1.0 in the coordinate fixed-point format
    localparam logic signed [COORD_W-1:0] ONE =
        {{(COORD_W-FRAC_W-1){1'b0}}, 1'b1, {FRAC_W{1'b0}}};

    // Default frame geometry
    localparam int DEF_H_RES = 320;
    localparam int DEF_V_RES = 240;
    localparam int DEF_IDX_W = $clog2(DEF_H_RES * DEF_V_RES);
    localparam int DEF_TAG_W = 2;

    // One dispatched work item at the default geometry
    typedef struct packed {
        logic [DEF_TAG_W-1:0]        tag;
        logic [DEF_IDX_W-1:0]        idx;
        logic signed [COORD_W-1:0]   x0;
        logic signed [COORD_W-1:0]   y0;
    } entry_t;

    // Width of an index into n items; a single item still needs one bit
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/coord_fifo.sv
// Show-ahead FIFO for one worker channel. The head entry is always visible
// on o_data while o_valid is high; o_data reads as zero when empty so the
// channel outputs are clean after reset and flush.
module coord_fifo
    import mandel_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              i_flush,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic              o_full,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    localparam int PTR_W = clog2_min1(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_push;
    logic              w_pop;

    // Full is judged on the pre-edge count, so a full FIFO being popped
    // still refuses a push in that same cycle.
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_valid = (r_count != '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && o_valid;
    assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;

    // Pointer and occupancy tracking; flush empties the FIFO in one edge
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents are only observed through the valid-gated head
    always_ff @(posedge clock) begin
        if (w_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/pixel_coord_dispatcher.sv
// Walks one frame in raster order, computing the complex-plane start point of
// every pixel, and deals the entries round-robin to NUM_CH worker FIFOs.
// A view load restarts the frame; frame_done pulses when the last pixel leaves.
module pixel_coord_dispatcher
    import mandel_pkg::clog2_min1;
#(
    parameter int NUM_CH  = 4,
    parameter int H_RES   = mandel_pkg::DEF_H_RES,
    parameter int V_RES   = mandel_pkg::DEF_V_RES,
    parameter int COORD_W = mandel_pkg::COORD_W,
    parameter int FRAC_W  = mandel_pkg::FRAC_W,
    parameter int DEPTH   = 4,
    parameter int IDX_W   = $clog2(H_RES * V_RES),
    parameter int TAG_W   = 2
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       view_load,
    input  logic [COORD_W-1:0]         x_origin_in,
    input  logic [COORD_W-1:0]         y_origin_in,
    input  logic [COORD_W-1:0]         x_step_in,
    input  logic [COORD_W-1:0]         y_step_in,
    input  logic [NUM_CH-1:0]          read_req,
    output logic [NUM_CH-1:0]          ready_for_read,
    output logic [NUM_CH*IDX_W-1:0]    idx_out,
    output logic [NUM_CH*COORD_W-1:0]  x0_out,
    output logic [NUM_CH*COORD_W-1:0]  y0_out,
    output logic [NUM_CH*TAG_W-1:0]    tag_out,
    output logic                       frame_busy,
    output logic                       frame_done
);

    localparam int TOTAL = H_RES * V_RES;
    localparam int CH_W  = clog2_min1(NUM_CH);
    localparam int COL_W = clog2_min1(H_RES);
    localparam int GEN_W = IDX_W + 1;   // must reach TOTAL itself
    localparam int ENT_W = TAG_W + IDX_W + 2 * COORD_W;

    // The datapath is scale-agnostic; the binary point only matters to
    // whoever loads the view. A fraction wider than the word is meaningless.
    if (FRAC_W >= COORD_W) begin : g_frac_exceeds_word
    end

    // View registers. The y origin is consumed directly into r_gen_y on load
    // and never needed again, so only the x origin is kept for row wrap.
    logic [COORD_W-1:0] r_x_origin;
    logic [COORD_W-1:0] r_x_step;
    logic [COORD_W-1:0] r_y_step;

    // Generator state
    logic [GEN_W-1:0]   r_gen_idx;
    logic [COORD_W-1:0] r_gen_x;
    logic [COORD_W-1:0] r_gen_y;
    logic [COL_W-1:0]   r_col;
    logic [CH_W-1:0]    r_rr_ptr;
    logic [TAG_W-1:0]   r_tag;
    logic               r_frame_busy;
    logic               r_frame_done;

    logic [NUM_CH-1:0]  w_full;
    logic [NUM_CH-1:0]  w_valid;
    logic [NUM_CH-1:0]  w_push;
    logic [NUM_CH-1:0]  w_pop;
    logic [NUM_CH-1:0]  w_last_hit;
    logic [ENT_W-1:0]   w_head [NUM_CH];
    logic [ENT_W-1:0]   w_push_data;
    logic [CH_W-1:0]    w_sel;
    logic               w_sel_found;
    logic               w_gen_en;
    logic               w_last_pop;

    assign w_push_data = {r_tag, r_gen_idx[IDX_W-1:0], r_gen_x, r_gen_y};

    // Pick the first non-full channel at or after the round-robin pointer
    always_comb begin
        int v_sum;
        w_sel       = '0;
        w_sel_found = 1'b0;
        v_sum       = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            v_sum = int'(r_rr_ptr) + k;
            if (v_sum >= NUM_CH) v_sum = v_sum - NUM_CH;
            if (!w_sel_found && !w_full[CH_W'(v_sum)]) begin
                w_sel       = CH_W'(v_sum);
                w_sel_found = 1'b1;
            end
        end
    end

    // A view load in the same cycle wins: no push, no pop, FIFOs flush
    assign w_gen_en   = r_frame_busy && (r_gen_idx < GEN_W'(TOTAL))
                        && w_sel_found && !view_load;
    assign w_last_pop = |w_last_hit;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign w_push[gi]     = w_gen_en && (w_sel == CH_W'(gi));
        assign w_pop[gi]      = read_req[gi] && w_valid[gi] && !view_load;
        assign w_last_hit[gi] = w_pop[gi]
                                && (w_head[gi][2*COORD_W +: IDX_W] == IDX_W'(TOTAL - 1));

        coord_fifo #(
            .DEPTH  (DEPTH),
            .DATA_W (ENT_W)
        ) u_fifo (
            .clock   (clock),
            .reset_n (reset_n),
            .i_flush (view_load),
            .i_push  (w_push[gi]),
            .i_data  (w_push_data),
            .i_pop   (w_pop[gi]),
            .o_full  (w_full[gi]),
            .o_valid (w_valid[gi]),
            .o_data  (w_head[gi])
        );

        assign ready_for_read[gi]              = w_valid[gi];
        assign tag_out[gi*TAG_W +: TAG_W]      = w_head[gi][ENT_W-1 -: TAG_W];
        assign idx_out[gi*IDX_W +: IDX_W]      = w_head[gi][2*COORD_W +: IDX_W];
        assign x0_out[gi*COORD_W +: COORD_W]   = w_head[gi][COORD_W +: COORD_W];
        assign y0_out[gi*COORD_W +: COORD_W]   = w_head[gi][0 +: COORD_W];
    end

    assign frame_busy = r_frame_busy;
    assign frame_done = r_frame_done;

    // View latch, coordinate accumulators, round-robin pointer and frame tracking
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_x_origin   <= '0;
            r_x_step     <= '0;
            r_y_step     <= '0;
            r_gen_idx    <= '0;
            r_gen_x      <= '0;
            r_gen_y      <= '0;
            r_col        <= '0;
            r_rr_ptr     <= '0;
            r_tag        <= '0;
            r_frame_busy <= 1'b0;
            r_frame_done <= 1'b0;
        end else if (view_load) begin
            r_x_origin   <= x_origin_in;
            r_x_step     <= x_step_in;
            r_y_step     <= y_step_in;
            r_gen_idx    <= '0;
            r_gen_x      <= x_origin_in;
            r_gen_y      <= y_origin_in;
            r_col        <= '0;
            r_tag        <= r_tag + TAG_W'(1);
            r_frame_busy <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_last_pop;
            if (w_last_pop) r_frame_busy <= 1'b0;
            if (w_gen_en) begin
                r_gen_idx <= r_gen_idx + GEN_W'(1);
                r_rr_ptr  <= (w_sel == CH_W'(NUM_CH - 1)) ? '0 : w_sel + CH_W'(1);
                if (r_col < COL_W'(H_RES - 1)) begin
                    r_gen_x <= r_gen_x + r_x_step;
                    r_col   <= r_col + COL_W'(1);
                end else begin
                    r_gen_x <= r_x_origin;
                    r_col   <= '0;
                    r_gen_y <= r_gen_y - r_y_step;
                end
            end
        end
    end

endmodule

// File: tb/tb_pixel_coord_dispatcher.sv
// Self-checking bench for pixel_coord_dispatcher in a 2-channel, 4x2 frame,
// depth-2 configuration. A queue-based reference model derives every entry
// from its pixel index (col = idx % H, row = idx / H).
module tb_pixel_coord_dispatcher;

    localparam int NCH = 2;
    localparam int H   = 4;
    localparam int V   = 2;
    localparam int TOT = H * V;
    localparam int DEP = 2;
    localparam int IW  = 3;
    localparam int TW  = 2;
    localparam int CW  = 64;

    localparam logic [63:0] ONE   = 64'h0100_0000_0000_0000;
    localparam logic [63:0] HALF  = 64'h0080_0000_0000_0000;
    localparam logic [63:0] N2_0  = 64'hFE00_0000_0000_0000;
    localparam logic [63:0] N1_5  = 64'hFE80_0000_0000_0000;
    localparam logic [63:0] N0_5  = 64'hFF80_0000_0000_0000;

    logic                clock = 1'b0;
    logic                reset_n = 1'b0;
    logic                view_load = 1'b0;
    logic [CW-1:0]       x_origin_in = '0;
    logic [CW-1:0]       y_origin_in = '0;
    logic [CW-1:0]       x_step_in = '0;
    logic [CW-1:0]       y_step_in = '0;
    logic [NCH-1:0]      read_req = '0;
    logic [NCH-1:0]      ready_for_read;
    logic [NCH*IW-1:0]   idx_out;
    logic [NCH*CW-1:0]   x0_out;
    logic [NCH*CW-1:0]   y0_out;
    logic [NCH*TW-1:0]   tag_out;
    logic                frame_busy;
    logic                frame_done;

    int n_cmp = 0;
    int n_bad = 0;

    pixel_coord_dispatcher #(
        .NUM_CH(NCH), .H_RES(H), .V_RES(V), .COORD_W(CW), .FRAC_W(56),
        .DEPTH(DEP), .IDX_W(IW), .TAG_W(TW)
    ) dut (
        .clock(clock), .reset_n(reset_n), .view_load(view_load),
        .x_origin_in(x_origin_in), .y_origin_in(y_origin_in),
        .x_step_in(x_step_in), .y_step_in(y_step_in),
        .read_req(read_req), .ready_for_read(ready_for_read),
        .idx_out(idx_out), .x0_out(x0_out), .y0_out(y0_out), .tag_out(tag_out),
        .frame_busy(frame_busy), .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [TW-1:0] tag;
        logic [IW-1:0] idx;
        logic [CW-1:0] x0;
        logic [CW-1:0] y0;
    } ment_t;

    ment_t       mq [NCH][$];
    int          m_rr, m_gen;
    bit          m_busy, m_done;
    logic [TW-1:0] m_tag;
    logic [CW-1:0] m_xo, m_yo, m_xs, m_ys;

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) mq[c].delete();
        m_rr = 0; m_gen = 0; m_busy = 0; m_done = 0; m_tag = '0;
        m_xo = '0; m_yo = '0; m_xs = '0; m_ys = '0;
    endfunction

    function automatic ment_t make_entry();
        ment_t e;
        int col, row;
        col   = m_gen % H;
        row   = m_gen / H;
        e.tag = m_tag;
        e.idx = IW'(m_gen);
        e.x0  = m_xo + 64'(col) * m_xs;
        e.y0  = m_yo - 64'(row) * m_ys;
        return e;
    endfunction

    function automatic void model_update(input logic vl, input logic [NCH-1:0] rq);
        int    pre [NCH];
        bit    was_busy;
        ment_t e;
        int    c2;
        for (int c = 0; c < NCH; c++) pre[c] = mq[c].size();
        was_busy = m_busy;
        if (vl) begin
            for (int c = 0; c < NCH; c++) mq[c].delete();
            m_xo = x_origin_in; m_yo = y_origin_in; m_xs = x_step_in; m_ys = y_step_in;
            m_gen = 0; m_tag = m_tag + 2'd1; m_busy = 1; m_done = 0;
        end else begin
            m_done = 0;
            for (int c = 0; c < NCH; c++) begin
                if (rq[c] && pre[c] > 0) begin
                    e = mq[c].pop_front();
                    if (int'(e.idx) == TOT - 1) begin
                        m_done = 1;
                        m_busy = 0;
                    end
                end
            end
            if (was_busy && m_gen < TOT) begin
                for (int k = 0; k < NCH; k++) begin
                    c2 = (m_rr + k) % NCH;
                    if (pre[c2] < DEP) begin
                        mq[c2].push_back(make_entry());
                        m_rr = (c2 + 1) % NCH;
                        m_gen++;
                        break;
                    end
                end
            end
        end
    endfunction

    // One clock: drive inputs, take the edge, advance the model, settle
    task automatic step(input logic vl, input logic [NCH-1:0] rq);
        view_load = vl;
        read_req  = rq;
        @(posedge clock);
        model_update(vl, rq);
        #1;
        view_load = 1'b0;
    endtask

    task automatic set_view(input logic [CW-1:0] xo, input logic [CW-1:0] yo,
                            input logic [CW-1:0] xs, input logic [CW-1:0] ys);
        x_origin_in = xo; y_origin_in = yo; x_step_in = xs; y_step_in = ys;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        read_req = '0;
        repeat (3) @(posedge clock);
        #1;
        model_reset();
        n_cmp++; if (ready_for_read !== 2'b00) begin n_bad++; $display("FAIL reset_ready got %b want 00", ready_for_read); end
        n_cmp++; if (idx_out !== '0) begin n_bad++; $display("FAIL reset_idx got %h want 0", idx_out); end
        n_cmp++; if (x0_out !== '0 || y0_out !== '0) begin n_bad++; $display("FAIL reset_coord got %h/%h want 0", x0_out, y0_out); end
        n_cmp++; if (tag_out !== '0) begin n_bad++; $display("FAIL reset_tag got %h want 0", tag_out); end
        n_cmp++; if (frame_busy !== 1'b0 || frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_frame got busy=%b done=%b want 0/0", frame_busy, frame_done); end
        #3 reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 2'b11);
            $display("reset idle cyc=%0d rdy=%b busy=%b", i, ready_for_read, frame_busy);
            n_cmp++; if (ready_for_read !== 2'b00 || frame_busy !== 1'b0) begin n_bad++; $display("FAIL idle_after_reset got rdy=%b busy=%b want 00/0", ready_for_read, frame_busy); end
        end
    endtask

    task automatic test_fill();
        set_view(N2_0, ONE, HALF, HALF);
        step(1'b1, 2'b00);
        n_cmp++; if (ready_for_read !== 2'b00 || frame_busy !== 1'b1) begin n_bad++; $display("FAIL load_edge got rdy=%b busy=%b want 00/1", ready_for_read, frame_busy); end
        step(1'b0, 2'b00);
        n_cmp++; if (ready_for_read !== 2'b01) begin n_bad++; $display("FAIL first_push got rdy=%b want 01", ready_for_read); end
        n_cmp++; if (idx_out[IW-1:0] !== 3'd0 || x0_out[CW-1:0] !== N2_0 || y0_out[CW-1:0] !== ONE || tag_out[TW-1:0] !== 2'd1)
            begin n_bad++; $display("FAIL first_entry got idx=%0d x0=%h y0=%h tag=%0d want 0/%h/%h/1", idx_out[IW-1:0], x0_out[CW-1:0], y0_out[CW-1:0], tag_out[TW-1:0], N2_0, ONE); end
        repeat (5) step(1'b0, 2'b00);
        $display("fill rdy=%b idx0=%0d idx1=%0d", ready_for_read, idx_out[IW-1:0], idx_out[IW +: IW]);
        n_cmp++; if (ready_for_read !== 2'b11) begin n_bad++; $display("FAIL fill_ready got %b want 11", ready_for_read); end
        n_cmp++; if (idx_out[IW-1:0] !== 3'd0) begin n_bad++; $display("FAIL fill_ch0_head got %0d want 0", idx_out[IW-1:0]); end
        n_cmp++; if (idx_out[IW +: IW] !== 3'd1 || x0_out[CW +: CW] !== N1_5 || y0_out[CW +: CW] !== ONE)
            begin n_bad++; $display("FAIL fill_ch1_head got idx=%0d x0=%h y0=%h want 1/%h/%h", idx_out[IW +: IW], x0_out[CW +: CW], y0_out[CW +: CW], N1_5, ONE); end
    endtask

    task automatic test_drain();
        int pops, done_cnt;
        bit hit_last;
        logic [IW-1:0] id;
        ment_t got;
        pops = 0; done_cnt = 0;
        for (int cyc = 0; cyc < 30 && pops < TOT; cyc++) begin
            hit_last = 0;
            for (int ch = 0; ch < NCH; ch++) begin
                if (ready_for_read[ch]) begin
                    id  = idx_out[ch*IW +: IW];
                    got = {tag_out[ch*TW +: TW], id, x0_out[ch*CW +: CW], y0_out[ch*CW +: CW]};
                    $display("drain pop ch%0d idx=%0d x0=%h y0=%h", ch, id, got.x0, got.y0);
                    pops++;
                    n_cmp++; if (mq[ch].size() == 0 || got !== mq[ch][0]) begin n_bad++; $display("FAIL drain_entry ch%0d got idx=%0d x0=%h y0=%h vs model", ch, id, got.x0, got.y0); end
                    if (id == 3'd4) begin
                        n_cmp++; if (got.x0 !== N2_0 || got.y0 !== HALF) begin n_bad++; $display("FAIL idx4_coord got %h/%h want %h/%h", got.x0, got.y0, N2_0, HALF); end
                    end
                    if (id == 3'd7) begin
                        hit_last = 1;
                        n_cmp++; if (got.x0 !== N0_5 || got.y0 !== HALF) begin n_bad++; $display("FAIL idx7_coord got %h/%h want %h/%h", got.x0, got.y0, N0_5, HALF); end
                    end
                end
            end
            step(1'b0, 2'b11);
            if (frame_done === 1'b1) done_cnt++;
            n_cmp++; if (frame_done !== hit_last) begin n_bad++; $display("FAIL drain_done got %b want %b", frame_done, hit_last); end
        end
        n_cmp++; if (pops != TOT) begin n_bad++; $display("FAIL drain_count got %0d want %0d", pops, TOT); end
        n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL drain_done_pulses got %0d want 1", done_cnt); end
        n_cmp++; if (frame_busy !== 1'b0) begin n_bad++; $display("FAIL drain_busy got %b want 0", frame_busy); end
        repeat (2) begin
            step(1'b0, 2'b11);
            n_cmp++; if (ready_for_read !== 2'b00 || frame_done !== 1'b0) begin n_bad++; $display("FAIL drain_idle got rdy=%b done=%b want 00/0", ready_for_read, frame_done); end
        end
    endtask

    task automatic test_ch0_only();
        int seen [TOT];
        int done_cnt;
        for (int i = 0; i < TOT; i++) seen[i] = 0;
        done_cnt = 0;
        set_view(N2_0, ONE, HALF, HALF);
        step(1'b1, 2'b00);
        repeat (5) step(1'b0, 2'b00);
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (ready_for_read[0]) begin
                $display("ch0only pop ch0 idx=%0d", idx_out[IW-1:0]);
                seen[idx_out[IW-1:0]]++;
            end
            step(1'b0, 2'b01);
            if (frame_done === 1'b1) done_cnt++;
        end
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (ready_for_read[1]) begin
                $display("ch0only pop ch1 idx=%0d", idx_out[IW +: IW]);
                seen[idx_out[IW +: IW]]++;
            end
            step(1'b0, 2'b10);
            if (frame_done === 1'b1) done_cnt++;
        end
        for (int i = 0; i < TOT; i++) begin
            n_cmp++; if (seen[i] != 1) begin n_bad++; $display("FAIL ch0only_idx%0d seen %0d times want 1", i, seen[i]); end
        end
        n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL ch0only_done got %0d want 1", done_cnt); end
        n_cmp++; if (ready_for_read !== 2'b00 || frame_busy !== 1'b0) begin n_bad++; $display("FAIL ch0only_end got rdy=%b busy=%b want 00/0", ready_for_read, frame_busy); end
    endtask

    task automatic test_reload();
        logic [TW-1:0] exp_tag;
        bit saw_done;
        saw_done = 0;
        set_view(N2_0, ONE, HALF, HALF);
        step(1'b1, 2'b00);
        repeat (5) step(1'b0, 2'b00);
        step(1'b0, 2'b11);
        if (frame_done === 1'b1) saw_done = 1;
        step(1'b0, 2'b01);
        if (frame_done === 1'b1) saw_done = 1;
        exp_tag = m_tag + 2'd1;
        set_view('0, '0, HALF, HALF);
        step(1'b1, 2'b11);
        $display("reload edge rdy=%b done=%b", ready_for_read, frame_done);
        n_cmp++; if (ready_for_read !== 2'b00) begin n_bad++; $display("FAIL reload_flush got %b want 00", ready_for_read); end
        step(1'b0, 2'b00);
        n_cmp++; if (ready_for_read !== 2'b01 || idx_out[IW-1:0] !== 3'd0 || x0_out[CW-1:0] !== 64'd0 || y0_out[CW-1:0] !== 64'd0)
            begin n_bad++; $display("FAIL reload_first got rdy=%b idx=%0d x0=%h y0=%h want 01/0/0/0", ready_for_read, idx_out[IW-1:0], x0_out[CW-1:0], y0_out[CW-1:0]); end
        n_cmp++; if (tag_out[TW-1:0] !== exp_tag) begin n_bad++; $display("FAIL reload_tag got %0d want %0d", tag_out[TW-1:0], exp_tag); end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 2'b00);
            if (frame_done === 1'b1) saw_done = 1;
        end
        n_cmp++; if (saw_done) begin n_bad++; $display("FAIL reload_no_done got a pulse want none"); end
    endtask

    task automatic test_random();
        logic [NCH-1:0] rq;
        logic vl;
        bit er;
        ment_t e, got;
        for (int f = 0; f < 4; f++) begin
            set_view({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
            step(1'b1, NCH'($urandom_range(0, 3)));
            for (int cyc = 0; cyc < 60; cyc++) begin
                vl = ($urandom_range(0, 39) == 0);
                if (vl) set_view({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
                rq = NCH'($urandom_range(0, 3));
                step(vl, rq);
                $display("rnd f=%0d cyc=%0d vl=%b rq=%b rdy=%b busy=%b done=%b", f, cyc, vl, rq, ready_for_read, frame_busy, frame_done);
                for (int ch = 0; ch < NCH; ch++) begin
                    er = (mq[ch].size() > 0);
                    n_cmp++; if (ready_for_read[ch] !== er) begin n_bad++; $display("FAIL rnd_ready ch%0d got %b want %b", ch, ready_for_read[ch], er); end
                    if (er) begin
                        e   = mq[ch][0];
                        got = {tag_out[ch*TW +: TW], idx_out[ch*IW +: IW], x0_out[ch*CW +: CW], y0_out[ch*CW +: CW]};
                        n_cmp++; if (got !== e) begin n_bad++; $display("FAIL rnd_head ch%0d got t%0d i%0d %h %h want t%0d i%0d %h %h", ch, got.tag, got.idx, got.x0, got.y0, e.tag, e.idx, e.x0, e.y0); end
                    end
                end
                n_cmp++; if (frame_busy !== m_busy) begin n_bad++; $display("FAIL rnd_busy got %b want %b", frame_busy, m_busy); end
                n_cmp++; if (frame_done !== m_done) begin n_bad++; $display("FAIL rnd_done got %b want %b", frame_done, m_done); end
            end
        end
    endtask

    task automatic test_reset_mid();
        set_view(N2_0, ONE, HALF, HALF);
        step(1'b1, 2'b00);
        repeat (2) step(1'b0, 2'b00);
        reset_n = 1'b0;
        #2;
        model_reset();
        $display("midreset rdy=%b busy=%b tag=%h", ready_for_read, frame_busy, tag_out);
        n_cmp++; if (ready_for_read !== 2'b00 || idx_out !== '0 || x0_out !== '0 || y0_out !== '0 || tag_out !== '0 || frame_busy !== 1'b0 || frame_done !== 1'b0)
            begin n_bad++; $display("FAIL midreset_outputs got rdy=%b idx=%h tag=%h busy=%b done=%b want all 0", ready_for_read, idx_out, tag_out, frame_busy, frame_done); end
        @(posedge clock);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 2'b11);
            n_cmp++; if (ready_for_read !== 2'b00 || frame_busy !== 1'b0) begin n_bad++; $display("FAIL midreset_idle got rdy=%b busy=%b want 00/0", ready_for_read, frame_busy); end
        end
        step(1'b1, 2'b00);
        step(1'b0, 2'b00);
        n_cmp++; if (ready_for_read !== 2'b01 || tag_out[TW-1:0] !== 2'd1) begin n_bad++; $display("FAIL midreset_restart got rdy=%b tag=%0d want 01/1", ready_for_read, tag_out[TW-1:0]); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_ch0_only();
        test_reload();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
